// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage and its environment: control inputs, the
// instruction memory port and the registered fetch outputs.
interface instruction_fetch_if;
  logic       stall;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic [7:0] instruction_address;
  logic [7:0] instruction_data;
  logic       fetch_valid;
  logic [7:0] fetched_instruction;
  logic [7:0] fetched_pc;
  logic       addr_fault;
  logic       halted;

  modport master (
    input  stall,
    input  branch_valid,
    input  branch_target,
    input  instruction_data,
    output instruction_address,
    output fetch_valid,
    output fetched_instruction,
    output fetched_pc,
    output addr_fault,
    output halted
  );

  modport slave (
    output stall,
    output branch_valid,
    output branch_target,
    output instruction_data,
    input  instruction_address,
    input  fetch_valid,
    input  fetched_instruction,
    input  fetched_pc,
    input  addr_fault,
    input  halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch with branch redirect, one-bubble flush and stall hold.
// Optional macro FETCH_HALT_EN adds a HALT state entered on fetching HALT_OPCODE.
module instruction_fetch #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned MEM_DEPTH   = 6,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  localparam logic [7:0] LastPc = 8'(MEM_DEPTH - 1);

`ifdef FETCH_HALT_EN
  localparam bit HaltEn = 1'b1;
  typedef enum logic [1:0] {StFetch, StFlush, StHalt} state_e;
`else
  localparam bit HaltEn = 1'b0;
  typedef enum logic [1:0] {StFetch, StFlush} state_e;
`endif

  state_e     state_q;
  logic [7:0] pc_q;
  logic [7:0] fetched_instruction_q;
  logic [7:0] fetched_pc_q;
  logic       fetch_valid_q;
  logic       addr_fault_q;

  logic [7:0] pc_inc;
  logic       target_ok;
  logic       halt_hit;

  assign pc_inc    = (pc_q == LastPc) ? 8'h00 : pc_q + 8'h01;
  assign target_ok = 32'(bus.branch_target) < MEM_DEPTH;
  // Constant-false when the halt feature is not built.
  assign halt_hit  = HaltEn && (bus.instruction_data == HALT_OPCODE);

`ifdef FETCH_HALT_EN
  logic halted_q;
  assign bus.halted = halted_q;
`else
  assign bus.halted = halt_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= StFetch;
      pc_q                  <= RESET_PC;
      fetched_instruction_q <= 8'h00;
      fetched_pc_q          <= 8'h00;
      fetch_valid_q         <= 1'b0;
      addr_fault_q          <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q              <= 1'b0;
`endif
    end else begin
      case (state_q)
        StFetch, StFlush: begin
          if (bus.branch_valid) begin
            // Out-of-range targets are redirected to 0 so the PC stays a legal index.
            pc_q          <= target_ok ? bus.branch_target : 8'h00;
            fetch_valid_q <= 1'b0;
            state_q       <= StFlush;
            if (!target_ok) begin
              addr_fault_q <= 1'b1;
            end
          end else if (!bus.stall) begin
            fetched_instruction_q <= bus.instruction_data;
            fetched_pc_q          <= pc_q;
            fetch_valid_q         <= 1'b1;
            pc_q                  <= pc_inc;
`ifdef FETCH_HALT_EN
            state_q               <= halt_hit ? StHalt : StFetch;
            halted_q              <= halt_hit;
`else
            state_q               <= StFetch;
`endif
          end
        end
`ifdef FETCH_HALT_EN
        StHalt: begin
          fetch_valid_q <= 1'b0;
        end
`endif
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

  assign bus.instruction_address = pc_q;
  assign bus.fetch_valid         = fetch_valid_q;
  assign bus.fetched_instruction = fetched_instruction_q;
  assign bus.fetched_pc          = fetched_pc_q;
  assign bus.addr_fault          = addr_fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, branch, fault,
// reset during flush and (when FETCH_HALT_EN is defined) the halt path.
module tb_instruction_fetch;

  logic clk;
  logic rst;
  logic [7:0] mem [0:7];
  int n_checks;
  int n_errors;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC    (8'h00),
    .MEM_DEPTH   (6),
    .HALT_OPCODE (8'hFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.instruction_data = (bus.instruction_address < 8'd8) ?
                                mem[bus.instruction_address[2:0]] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input logic [7:0] pc, input logic [7:0] data);
    check({tag, "_valid"}, 8'(bus.fetch_valid), 8'h01);
    check({tag, "_pc"}, bus.fetched_pc, pc);
    check({tag, "_data"}, bus.fetched_instruction, data);
  endtask

  task automatic expect_reset(input string tag);
    check({tag, "_valid"}, 8'(bus.fetch_valid), 8'h00);
    check({tag, "_instr"}, bus.fetched_instruction, 8'h00);
    check({tag, "_fpc"}, bus.fetched_pc, 8'h00);
    check({tag, "_fault"}, 8'(bus.addr_fault), 8'h00);
    check({tag, "_halted"}, 8'(bus.halted), 8'h00);
    check({tag, "_addr"}, bus.instruction_address, 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 8'h00;
    step();
    step();
    expect_reset("reset");

    // Free-running fetch with wrap from 5 to 0.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_fetch($sformatf("run%0d", i), 8'(i % 6), 8'h10 + 8'(i % 6));
    end
    step();
    expect_fetch("pre_stall", 8'h02, 8'h12);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_fetch($sformatf("stall%0d", i), 8'h02, 8'h12);
    end
    bus.stall = 1'b0;
    step();
    expect_fetch("resume", 8'h03, 8'h13);

    // Branch wins over stall.
    bus.stall         = 1'b1;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h04;
    step();
    check("br4_bubble", 8'(bus.fetch_valid), 8'h00);
    check("br4_addr", bus.instruction_address, 8'h04);
    bus.stall        = 1'b0;
    bus.branch_valid = 1'b0;
    step();
    expect_fetch("br4", 8'h04, 8'h14);

    // Out-of-range target redirects to 0 and sets the sticky fault.
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h09;
    step();
    check("fault_set", 8'(bus.addr_fault), 8'h01);
    check("fault_bubble", 8'(bus.fetch_valid), 8'h00);
    check("fault_addr", bus.instruction_address, 8'h00);
    bus.branch_valid = 1'b0;
    step();
    expect_fetch("fault_fetch", 8'h00, 8'h10);
    check("fault_sticky1", 8'(bus.addr_fault), 8'h01);

    // Last legal index is accepted, then wraps.
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h05;
    step();
    check("br5_addr", bus.instruction_address, 8'h05);
    check("br5_bubble", 8'(bus.fetch_valid), 8'h00);
    bus.branch_valid = 1'b0;
    step();
    expect_fetch("br5", 8'h05, 8'h15);
    step();
    expect_fetch("br5_wrap", 8'h00, 8'h10);
    check("fault_sticky2", 8'(bus.addr_fault), 8'h01);

    // Reset in FLUSH overrides a simultaneous branch.
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h02;
    step();
    check("flush_addr", bus.instruction_address, 8'h02);
    rst = 1'b1;
    step();
    expect_reset("rst_flush");
    rst              = 1'b0;
    bus.branch_valid = 1'b0;
    step();
    expect_fetch("first_after_rst", 8'h00, 8'h10);

    mem[3] = 8'hFF;
    step();
    step();
    step();
    expect_fetch("op_ff", 8'h03, 8'hFF);
`ifdef FETCH_HALT_EN
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h01;
    bus.stall         = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("halt%0d_halted", i), 8'(bus.halted), 8'h01);
      check($sformatf("halt%0d_valid", i), 8'(bus.fetch_valid), 8'h00);
      check($sformatf("halt%0d_fpc", i), bus.fetched_pc, 8'h03);
      check($sformatf("halt%0d_addr", i), bus.instruction_address, 8'h04);
    end
    bus.branch_valid = 1'b0;
    bus.stall        = 1'b0;
    rst              = 1'b1;
    step();
    expect_reset("rst_halt");
    rst = 1'b0;
    step();
    expect_fetch("restart", 8'h00, 8'h10);
`else
    step();
    expect_fetch("op_ff_next", 8'h04, 8'h14);
    check("no_halt", 8'(bus.halted), 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, the PC value loaded on reset.
REQ-002 Parameter MEM_DEPTH, default 6, the number of valid instruction memory entries (addresses 0..MEM_DEPTH-1).
REQ-003 Parameter HALT_OPCODE, default 8'hFF, the instruction encoding that stops fetch when FETCH_HALT_EN is defined.
REQ-004 clk  input  1  the single clock; every register updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 stall  input  1  downstream is not ready; hold the current fetch output.
REQ-007 branch_valid  input  1  redirect the PC this cycle.
REQ-008 branch_target  input  8  redirect address.
REQ-009 instruction_address  output  8  address to the instruction memory; driven directly from the PC register.
REQ-010 instruction_data  input  8  combinational read data from the instruction memory at instruction_address.
REQ-011 fetch_valid  output  1  fetched_instruction and fetched_pc hold a valid instruction.
REQ-012 fetched_instruction  output  8  instruction register.
REQ-013 fetched_pc  output  8  address the instruction register was fetched from.
REQ-014 addr_fault  output  1  sticky flag: a branch targeted an address >= MEM_DEPTH.
REQ-015 halted  output  1  high while in the HALT state.

Function
REQ-016 States: FETCH, FLUSH and HALT; there is no other state.
REQ-017 Priority order each cycle: rst, then branch_valid, then stall, then normal fetch.
REQ-018 FETCH, no stall, no branch:
- fetched_instruction <= instruction_data
- fetched_pc <= PC
- fetch_valid <= 1
- PC <= PC+1, wrapping from MEM_DEPTH-1 to 0
- latency: an address appears on the output registers one cycle after it is presented.
REQ-019 FETCH with stall and no branch: PC, fetched_instruction, fetched_pc and fetch_valid hold their values.
REQ-020 branch_valid in FETCH or FLUSH, regardless of stall:
- PC <= branch_target
- fetch_valid <= 0
- next state is FLUSH.
REQ-021 FLUSH with no branch: perform the REQ-018 fetch at the new PC and return to FETCH (branch penalty of one bubble cycle).
REQ-022 If branch_target >= MEM_DEPTH: PC <= 0 instead of the target, and addr_fault <= 1 until reset.
REQ-023 The PC never leaves the range 0..MEM_DEPTH-1; instruction_address is always a legal memory index.
REQ-024 HALT:
- PC, fetched_instruction and fetched_pc frozen
- fetch_valid is 0
- branch_valid and stall are ignored
- only rst exits.

Reset
REQ-025 When rst is high at a rising edge, the block SHALL set:
- PC = RESET_PC
- fetch_valid = 0
- fetched_instruction = 8'h00
- fetched_pc = 8'h00
- addr_fault = 0
- halted = 0
- state = FETCH.
REQ-026 Reset asserted mid-stall, mid-flush or in HALT SHALL take effect on that edge and override every other input.
REQ-027 The first valid fetch completes on the first edge after rst deasserts.

Configuration
REQ-028 Macro FETCH_HALT_EN:
- Defined: when an instruction equal to HALT_OPCODE is registered into fetched_instruction, fetch_valid is 1 for that instruction, the next state is HALT, and halted is 1 from the following cycle.
- Undefined: HALT_OPCODE is treated as an ordinary instruction, the HALT state is not built, and halted is tied to 0.

Verification
REQ-029 Memory contents 8'h10..8'h15, reset then 8 free-running cycles -> fetched_pc sequence 0,1,2,3,4,5,0,1 with matching data and fetch_valid=1 from the first post-reset edge.
REQ-030 stall held high for 3 cycles at fetched_pc=2 -> outputs frozen at pc 2 / data 8'h12, then resume with pc 3.
REQ-031 branch_valid with target 4 while stall=1 -> one cycle with fetch_valid=0, then fetched_pc=4 with data 8'h14.
REQ-032 branch_valid with target 8'h09 -> addr_fault=1, next valid fetched_pc=0, and addr_fault stays 1 until rst.
REQ-033 FETCH_HALT_EN defined, memory entry 3 = 8'hFF -> fetched_pc=3 is valid, then halted=1 and fetch_valid=0 with no further PC change; rst pulse -> PC=RESET_PC and fetching restarts.
REQ-034 rst asserted while in FLUSH -> next cycle shows every REQ-025 reset value.
